// File: rtl/memory_access.sv
// memory_access: LW/SW data-memory stage with req/ack handshake, upstream stall and bus timeout.
module memory_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] instruction_out,
  output logic [31:0] data_output,
  output logic [31:0] mem_data_output,
  output logic        valid_out,
  output logic        bus_error
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic {IDLE, MEM_WAIT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] inst_q, addr_q;
  logic is_mem, is_sw;
  always_comb begin
    is_mem = instruction_in[31:28] == 4'd0;
    is_sw = instruction_in[27];
    ready_out = state == IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      inst_q <= '0;
      addr_q <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      instruction_out <= '0;
      data_output <= '0;
      mem_data_output <= '0;
      valid_out <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (state == IDLE) begin
        if (valid_in && is_mem) begin
          mem_req <= 1'b1;
          mem_we <= is_sw;
          mem_addr <= alu_result_in;
          mem_wdata <= is_sw ? store_data_in : '0;
          inst_q <= instruction_in;
          addr_q <= alu_result_in;
          cnt <= '0;
          state <= MEM_WAIT;
        end else if (valid_in) begin
          instruction_out <= instruction_in;
          data_output <= alu_result_in;
          mem_data_output <= '0;
          valid_out <= 1'b1;
        end
      end else if (mem_ack) begin
        // ack wins over a coincident timeout
        mem_req <= 1'b0;
        instruction_out <= inst_q;
        data_output <= addr_q;
        mem_data_output <= (inst_q[31:27] == 5'd0) ? mem_rdata : '0;
        valid_out <= 1'b1;
        state <= IDLE;
      end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        mem_req <= 1'b0;
        bus_error <= 1'b1;
        state <= IDLE;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule
